slt_bus_sequencer: RTL and testbench
====================================

SLT_BUS_SEQUENCER -- requirements
Module: slt_bus_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 1, giving the buffer-hold cycles after a bus cycle ends (range 1..3).
REQ-002 The block SHALL have parameter WDOG_LIMIT, default 8'd255, giving the maximum ACTIVE cycles before timeout.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: SLT_CLOCK input 1, the MSX bus clock; SLT_RESETn input 1, asynchronous active-low reset.
REQ-004 The block SHALL have SLT_SLTSL input 1, active-low primary slot select.
REQ-005 The block SHALL have SLT_RDn and SLT_WEn, each input 1, active-low read and write strobes.
REQ-006 The block SHALL have SLT_A input 16, the CPU address.
REQ-007 The block SHALL have SUBSEL input 2, the sub-slot selected for the page SLT_A[15:14], from the expansion register.
REQ-008 The block SHALL have EXTBUSDIR input 4, active-low per-subslot BUSDIR requests.
REQ-009 The block SHALL have EXT_SLTSLn output 4, active-low per-subslot selects.
REQ-010 The block SHALL have BUF_OEn output 1, active-low data buffer enable.
REQ-011 The block SHALL have BUF_DIR output 1, where 1 means subslot-to-CPU.
REQ-012 The block SHALL have REG_RD_EN output 1, enabling the expansion register to drive the inverted value.
REQ-013 The block SHALL have REG_WR_STB output 1, a one-cycle expansion register load strobe.
REQ-014 The block SHALL have SLT_BUSDIR output 1, the active-low BUSDIR to the host.
REQ-015 The block SHALL have TIMEOUT output 1, a sticky watchdog flag.

Function
REQ-016 Inputs SHALL be sampled on the rising edge of SLT_CLOCK with a single register stage, with no synchronizer, because the bus is synchronous.
REQ-017 The FSM states SHALL be IDLE, REG_RD, REG_WR, MEM, HOLD and ERR.
REQ-018 From IDLE, with SLTSL=0 and exactly one strobe low, the FSM SHALL go to REG_RD or REG_WR when SLT_A==16'hFFFF, otherwise to MEM.
REQ-019 From IDLE, with SLTSL=0 and RDn=WEn=0, the FSM SHALL go to ERR with every output inactive, and return to IDLE only when both strobes are sampled high.
REQ-020 In REG_RD, REG_RD_EN SHALL be 1, BUF_DIR=1, BUF_OEn=0 and SLT_BUSDIR=0, with all EXT_SLTSLn high.
REQ-021 In REG_WR, REG_WR_STB SHALL pulse exactly one cycle, on the first cycle of the state, with no retrigger while WEn stays low.
REQ-022 EXT_SLTSLn[SUBSEL] SHALL be combinationally low while SLTSL=0 and SLT_A!=16'hFFFF, with zero latency, and all other bits high.
REQ-023 In MEM, BUF_OEn SHALL be 0, with BUF_DIR=1 on a read and 0 on a write.
REQ-024 In MEM, SLT_BUSDIR SHALL equal EXTBUSDIR[SUBSEL] on a read and 1 on a write.
REQ-025 REG_RD, REG_WR and MEM SHALL exit to HOLD when SLTSL is sampled high or both strobes are sampled high.
REQ-026 HOLD SHALL keep BUF_OEn and BUF_DIR unchanged for HOLD_CYC cycles, drive SLT_BUSDIR=1 and REG_RD_EN=0, then return to IDLE.
REQ-027 A new cycle request arriving during HOLD SHALL be taken only after HOLD completes; it SHALL NOT be dropped.
REQ-028 A change of SUBSEL inside MEM SHALL move EXT_SLTSLn immediately, while buffer direction and enable hold their values.

Reset
REQ-029 While SLT_RESETn=0, the block SHALL hold EXT_SLTSLn=4'b1111, BUF_OEn=1, BUF_DIR=0, REG_RD_EN=0, REG_WR_STB=0, SLT_BUSDIR=1, TIMEOUT=0, the FSM in IDLE and the counters at 0, all asynchronously.
REQ-030 A reset asserted mid-cycle SHALL abort the cycle immediately, with no REG_WR_STB emitted.
REQ-031 After reset release, the first request SHALL be decoded from IDLE normally.

Configuration
REQ-032 Macro SLT_WDOG_EN, when defined, SHALL enable an 8-bit counter that is cleared on entry to REG_RD, REG_WR or MEM and increments each cycle in those states.
REQ-033 With SLT_WDOG_EN defined, the counter reaching WDOG_LIMIT SHALL set TIMEOUT=1 and force the FSM to ERR; TIMEOUT SHALL clear only on reset.
REQ-034 With SLT_WDOG_EN undefined, TIMEOUT SHALL be constant 0, no counter logic SHALL be present, and the FSM SHALL be unaffected.

Structure
REQ-035 Shared package slt_seq_pkg SHALL contain the FSM state enum, the constant EXT_REG_ADDR=16'hFFFF, and the BUF_DIR encodings.
REQ-036 The watchdog SHALL be sub-module slt_wdog (counter plus sticky flag), instantiated only under SLT_WDOG_EN.

Verification
REQ-037 Write 8'h55 to FFFF: exactly one REG_WR_STB pulse, EXT_SLTSLn=1111 throughout, and HOLD lasting 1 cycle.
REQ-038 Read FFFF: REG_RD_EN=1, BUF_DIR=1, BUF_OEn=0, SLT_BUSDIR=0 in REG_RD; all outputs inactive one cycle after HOLD.
REQ-039 Read 8000 with SUBSEL=2 and EXTBUSDIR=4'b1011: EXT_SLTSLn=1011 and SLT_BUSDIR=0; with EXTBUSDIR=4'b1111, SLT_BUSDIR=1.
REQ-040 RDn and WEn low together at 4000: FSM goes to ERR, no REG_WR_STB, BUF_OEn=1; FSM returns to IDLE after both strobes go high.
REQ-041 SLT_RESETn pulled low during a FFFF write before the strobe cycle: no REG_WR_STB, and every output at its reset value within the same clock period.
REQ-042 With SLT_WDOG_EN defined, hold RDn low at C000 for 300 cycles: TIMEOUT=1 at cycle 255, FSM in ERR, and TIMEOUT still 1 after the strobes release.

Source files
------------

// File: rtl/slt_seq_pkg.sv
// Shared types and constants for the MSX slot bus sequencer.
package slt_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG_RD,
        ST_REG_WR,
        ST_MEM,
        ST_HOLD,
        ST_ERR
    } seq_state_e;

    localparam logic [15:0] EXT_REG_ADDR    = 16'hFFFF;
    localparam logic        BUFDIR_TO_CPU   = 1'b1;
    localparam logic        BUFDIR_FROM_CPU = 1'b0;
    localparam logic [3:0]  EXT_NONE        = 4'b1111;

    function automatic logic [3:0] subslot_sel_n(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/slt_bus_sequencer_wdog.sv
// Active-cycle watchdog: counter cleared on cycle entry, sticky TIMEOUT flag.
module slt_wdog
    import slt_seq_pkg::*;
#(
    parameter logic [7:0] WDOG_LIMIT = 8'd255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic act_i,
    output logic trip_o,
    output logic timeout_o
);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (act_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign trip_o    = act_i && !clr_i && (cnt_d == WDOG_LIMIT);
    assign timeout_o = timeout_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | trip_o;
        end
    end

endmodule

// File: rtl/slt_bus_sequencer.sv
// MSX slot bus sequencer: sub-slot decode, expansion register access and buffer control.
// Optional watchdog enabled by defining SLT_WDOG_EN.
module slt_bus_sequencer
    import slt_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYC   = 1,
    parameter logic [7:0]  WDOG_LIMIT = 8'd255
) (
    input  logic        SLT_CLOCK,
    input  logic        SLT_RESETn,
    input  logic        SLT_SLTSL,
    input  logic        SLT_RDn,
    input  logic        SLT_WEn,
    input  logic [15:0] SLT_A,
    input  logic [1:0]  SUBSEL,
    input  logic [3:0]  EXTBUSDIR,
    output logic [3:0]  EXT_SLTSLn,
    output logic        BUF_OEn,
    output logic        BUF_DIR,
    output logic        REG_RD_EN,
    output logic        REG_WR_STB,
    output logic        SLT_BUSDIR,
    output logic        TIMEOUT
);

    localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYC - 1);

    seq_state_e state_q;
    logic [1:0] hold_cnt_q;
    logic       mem_rd_q;
    logic       buf_oen_q, buf_dir_q, reg_rd_en_q, reg_wr_stb_q, busdir_q;

    logic req_rd, req_wr, both_low, cyc_end, is_reg, wdog_trip;

    assign req_rd   = !SLT_SLTSL && !SLT_RDn &&  SLT_WEn;
    assign req_wr   = !SLT_SLTSL &&  SLT_RDn && !SLT_WEn;
    assign both_low = !SLT_SLTSL && !SLT_RDn && !SLT_WEn;
    assign cyc_end  =  SLT_SLTSL || (SLT_RDn && SLT_WEn);
    assign is_reg   = (SLT_A == EXT_REG_ADDR);

`ifdef SLT_WDOG_EN
    logic wdog_clr, wdog_act;

    assign wdog_clr = (state_q == ST_IDLE) && (req_rd || req_wr);
    assign wdog_act = (state_q == ST_REG_RD) || (state_q == ST_REG_WR) || (state_q == ST_MEM);

    slt_wdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk_i     (SLT_CLOCK),
        .rst_ni    (SLT_RESETn),
        .clr_i     (wdog_clr),
        .act_i     (wdog_act),
        .trip_o    (wdog_trip),
        .timeout_o (TIMEOUT)
    );
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = ^WDOG_LIMIT;
    assign wdog_trip       = 1'b0;
    assign TIMEOUT         = 1'b0;
`endif

    // Sub-slot select is decoded straight from the pins so memory devices see zero latency.
    always_comb begin
        EXT_SLTSLn = EXT_NONE;
        if (SLT_RESETn && !SLT_SLTSL && !is_reg && (state_q != ST_ERR)) begin
            EXT_SLTSLn = subslot_sel_n(SUBSEL);
        end
    end

    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            state_q      <= ST_IDLE;
            hold_cnt_q   <= '0;
            mem_rd_q     <= 1'b0;
            buf_oen_q    <= 1'b1;
            buf_dir_q    <= BUFDIR_FROM_CPU;
            reg_rd_en_q  <= 1'b0;
            reg_wr_stb_q <= 1'b0;
            busdir_q     <= 1'b1;
        end else begin
            reg_wr_stb_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    hold_cnt_q <= '0;
                    if (both_low) begin
                        state_q <= ST_ERR;
                    end else if (req_rd || req_wr) begin
                        if (is_reg && req_rd) begin
                            state_q     <= ST_REG_RD;
                            reg_rd_en_q <= 1'b1;
                            buf_oen_q   <= 1'b0;
                            buf_dir_q   <= BUFDIR_TO_CPU;
                            busdir_q    <= 1'b0;
                        end else if (is_reg) begin
                            state_q      <= ST_REG_WR;
                            reg_wr_stb_q <= 1'b1;
                        end else begin
                            state_q   <= ST_MEM;
                            mem_rd_q  <= req_rd;
                            buf_oen_q <= 1'b0;
                            buf_dir_q <= req_rd ? BUFDIR_TO_CPU : BUFDIR_FROM_CPU;
                            busdir_q  <= req_rd ? EXTBUSDIR[SUBSEL] : 1'b1;
                        end
                    end
                end
                ST_REG_RD, ST_REG_WR, ST_MEM: begin
                    if (wdog_trip) begin
                        state_q     <= ST_ERR;
                        buf_oen_q   <= 1'b1;
                        buf_dir_q   <= BUFDIR_FROM_CPU;
                        reg_rd_en_q <= 1'b0;
                        busdir_q    <= 1'b1;
                    end else if (cyc_end) begin
                        // Buffer enable/direction are deliberately left as-is through HOLD.
                        state_q     <= ST_HOLD;
                        hold_cnt_q  <= '0;
                        reg_rd_en_q <= 1'b0;
                        busdir_q    <= 1'b1;
                    end else if (state_q == ST_MEM) begin
                        busdir_q <= mem_rd_q ? EXTBUSDIR[SUBSEL] : 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q   <= ST_IDLE;
                        buf_oen_q <= 1'b1;
                        buf_dir_q <= BUFDIR_FROM_CPU;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 2'd1;
                    end
                end
                ST_ERR: begin
                    if (SLT_RDn && SLT_WEn) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign BUF_OEn    = buf_oen_q;
    assign BUF_DIR    = buf_dir_q;
    assign REG_RD_EN  = reg_rd_en_q;
    assign REG_WR_STB = reg_wr_stb_q;
    assign SLT_BUSDIR = busdir_q;

endmodule

// File: tb/tb_slt_bus_sequencer.sv
// Scoreboard bench: a transaction-level timeline model predicts per-cycle outputs.
module tb_slt_bus_sequencer;

    localparam int unsigned HOLD = 1;
    localparam logic [7:0]  WLIM = 8'd255;
    localparam int          NE   = 2048;
`ifdef SLT_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    typedef enum int {K_RRD, K_RWR, K_MRD, K_MWR, K_ERR} kind_e;

    typedef struct {
        logic        rst, sltsl, rdn, wen;
        logic [15:0] a;
        logic [1:0]  sub;
        logic [3:0]  ebd;
    } drv_t;

    typedef struct packed {
        logic [3:0] ext;
        logic       oen, dir, rden, stb, busdir, tmo;
    } obs_t;

    localparam obs_t IDLE_O = '{4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n, sltsl, rdn, wen;
    logic [15:0] a;
    logic [1:0]  sub;
    logic [3:0]  ebd;
    logic [3:0]  ext_n;
    logic        oen, dir, rden, stb, busdir, tmo;

    drv_t drv[NE];
    obs_t exp_o[NE];
    bit   err_e[NE];
    bit   trip_e[NE];
    int   ne, ready;

    obs_t sb_q[$];
    obs_t mon_exp, mon_act;
    int   vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    slt_bus_sequencer #(
        .HOLD_CYC  (HOLD),
        .WDOG_LIMIT(WLIM)
    ) dut (
        .SLT_CLOCK (clk),
        .SLT_RESETn(rst_n),
        .SLT_SLTSL (sltsl),
        .SLT_RDn   (rdn),
        .SLT_WEn   (wen),
        .SLT_A     (a),
        .SUBSEL    (sub),
        .EXTBUSDIR (ebd),
        .EXT_SLTSLn(ext_n),
        .BUF_OEn   (oen),
        .BUF_DIR   (dir),
        .REG_RD_EN (rden),
        .REG_WR_STB(stb),
        .SLT_BUSDIR(busdir),
        .TIMEOUT   (tmo)
    );

    // Non-requesting bus pattern; hi forces both strobes released.
    function automatic drv_t idle_drv(input bit hi);
        drv_t d;
        d.rst = 1'b1;
        d.a   = 16'($urandom);
        d.sub = 2'($urandom);
        d.ebd = 4'($urandom);
        if (hi || $urandom_range(0, 1) == 0) begin
            d.sltsl = 1'($urandom);
            d.rdn   = 1'b1;
            d.wen   = 1'b1;
        end else begin
            d.sltsl = 1'b1;
            d.rdn   = 1'($urandom);
            d.wen   = 1'($urandom);
        end
        return d;
    endfunction

    function automatic obs_t bus_obs(input kind_e k, input int e, input bit first);
        obs_t       o;
        logic [3:0] bd;
        o  = IDLE_O;
        bd = drv[e].ebd;
        case (k)
            K_RRD: begin o.oen = 1'b0; o.dir = 1'b1; o.rden = 1'b1; o.busdir = 1'b0; end
            K_RWR: o.stb = first;
            K_MRD: begin o.oen = 1'b0; o.dir = 1'b1; o.busdir = bd[drv[e].sub]; end
            K_MWR: o.oen = 1'b0;
            default: ;
        endcase
        return o;
    endfunction

    // One bus transaction: strobes held len cycles, then gap idle cycles; rs>=0 asserts reset from that offset.
    task automatic add_txn(input kind_e k, input logic [15:0] addr, input int len, input int gap,
                           input int rs, input int fix_sub, input bit use_ebd, input logic [3:0] fix_ebd);
        int a_e, b_e, d_e, pe, t_e;
        bit trip;
        a_e  = ne;
        b_e  = ne + len - 1;
        trip = 1'b0;
        for (int e = a_e; e <= b_e; e++) begin
            drv[e].rst   = !(rs >= 0 && e >= a_e + rs);
            drv[e].sltsl = 1'b0;
            drv[e].rdn   = !(k == K_RRD || k == K_MRD || k == K_ERR);
            drv[e].wen   = !(k == K_RWR || k == K_MWR || k == K_ERR);
            drv[e].a     = addr;
            drv[e].sub   = (fix_sub >= 0) ? 2'(fix_sub) : 2'($urandom);
            drv[e].ebd   = use_ebd ? fix_ebd : 4'($urandom);
        end
        d_e = (ready > a_e) ? ready : a_e;
        pe  = (rs >= 0 && a_e + rs - 1 < b_e) ? a_e + rs - 1 : b_e;
        if (k == K_ERR) begin
            for (int e = d_e; e <= pe; e++) begin
                err_e[e] = 1'b1;
                exp_o[e] = IDLE_O;
            end
        end else begin
            if (WDOG && (pe - d_e + 1 > int'(WLIM))) begin
                t_e = d_e + int'(WLIM);
                trip_e[t_e] = 1'b1;
                for (int e = t_e; e <= pe; e++) begin
                    err_e[e] = 1'b1;
                    exp_o[e] = IDLE_O;
                end
                pe   = t_e - 1;
                trip = 1'b1;
            end
            for (int e = d_e; e <= pe; e++) exp_o[e] = bus_obs(k, e, e == d_e);
        end
        if (rs >= 0) begin
            for (int e = a_e + rs; e <= b_e; e++) begin
                exp_o[e] = IDLE_O;
                err_e[e] = 1'b0;
            end
            ready = b_e + 1;
        end else if (k == K_ERR || trip) begin
            ready = b_e + 2;
        end else begin
            for (int h = 1; h <= int'(HOLD); h++) begin
                exp_o[b_e + h]        = exp_o[b_e];
                exp_o[b_e + h].rden   = 1'b0;
                exp_o[b_e + h].stb    = 1'b0;
                exp_o[b_e + h].busdir = 1'b1;
            end
            ready = b_e + int'(HOLD) + 2;
        end
        for (int e = b_e + 1; e <= b_e + gap; e++) drv[e] = idle_drv(k == K_ERR || trip);
        ne = b_e + gap + 1;
    endtask

    task automatic build();
        kind_e k;
        int    len, gap, rs;
        bit    tm;
        for (int e = 0; e < NE; e++) begin
            drv[e]    = idle_drv(1'b1);
            exp_o[e]  = IDLE_O;
            err_e[e]  = 1'b0;
            trip_e[e] = 1'b0;
        end
        // Reset held with an active-looking request on the pins.
        for (int e = 0; e < 4; e++) begin
            drv[e].rst = 1'b0; drv[e].sltsl = 1'b0; drv[e].rdn = 1'b0; drv[e].a = 16'h1234;
        end
        ne    = 4;
        ready = 4;
        add_txn(K_RWR, 16'hFFFF, 3, 2, -1, -1, 1'b0, 4'h0);
        add_txn(K_RRD, 16'hFFFF, 3, 2, -1, -1, 1'b0, 4'h0);
        add_txn(K_MRD, 16'h8000, 3, 2, -1, 2, 1'b1, 4'b1011);
        add_txn(K_MRD, 16'h8000, 3, 2, -1, 2, 1'b1, 4'b1111);
        add_txn(K_ERR, 16'h4000, 3, 2, -1, -1, 1'b0, 4'h0);
        add_txn(K_RWR, 16'hFFFF, 3, 2, 0, -1, 1'b0, 4'h0);
        for (int t = 0; t < 60; t++) begin
            k   = kind_e'($urandom_range(0, 4));
            len = int'($urandom_range(HOLD + 1, 6));
            gap = int'($urandom_range(1, HOLD + 2));
            rs  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            if (k == K_RRD || k == K_RWR)
                add_txn(k, 16'hFFFF, len, gap, rs, -1, 1'b0, 4'h0);
            else
                add_txn(k, 16'($urandom_range(0, 16'hFFFE)), len, gap, rs, -1, 1'b0, 4'h0);
        end
        add_txn(K_MRD, 16'hC000, 300, 3, -1, -1, 1'b0, 4'h0);
        tm = 1'b0;
        for (int e = 0; e < ne; e++) begin
            if (!drv[e].rst) tm = 1'b0;
            else if (trip_e[e]) tm = 1'b1;
            exp_o[e].tmo = tm;
            exp_o[e].ext = (drv[e].rst && !drv[e].sltsl && drv[e].a != 16'hFFFF && !err_e[e])
                           ? ~(4'b0001 << drv[e].sub) : 4'hF;
        end
    endtask

    initial begin
        rst_n = 1'b0; sltsl = 1'b1; rdn = 1'b1; wen = 1'b1;
        a = '0; sub = '0; ebd = '1;
        build();
        for (int e = 0; e < ne; e++) begin
            @(negedge clk);
            rst_n = drv[e].rst;
            sltsl = drv[e].sltsl;
            rdn   = drv[e].rdn;
            wen   = drv[e].wen;
            a     = drv[e].a;
            sub   = drv[e].sub;
            ebd   = drv[e].ebd;
            sb_q.push_back(exp_o[e]);
        end
        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            mon_act = {ext_n, oen, dir, rden, stb, busdir, tmo};
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL vec%0d: got ext=%b oen=%b dir=%b rden=%b stb=%b busdir=%b tmo=%b, required ext=%b oen=%b dir=%b rden=%b stb=%b busdir=%b tmo=%b",
                         vectors, mon_act.ext, mon_act.oen, mon_act.dir, mon_act.rden, mon_act.stb,
                         mon_act.busdir, mon_act.tmo, mon_exp.ext, mon_exp.oen, mon_exp.dir,
                         mon_exp.rden, mon_exp.stb, mon_exp.busdir, mon_exp.tmo);
            end
            vectors++;
        end
    end

endmodule
